// File: rtl/if_fetch_if.sv
// Bus between the fetch stage and its surroundings: control inputs, program-load
// port, and the IF/ID-facing fetch outputs.
interface if_fetch_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic              stall;
  logic              pcsrc;
  logic [31:0]       branch_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [31:0]       pc;
  logic [31:0]       npc;
  logic [31:0]       instr;
  logic              valid;
  logic              halted;
  logic              addr_err;
  logic [15:0]       fetch_count;

  modport master (
    output start, stall, pcsrc, branch_target, imem_we, imem_waddr, imem_wdata,
    input  pc, npc, instr, valid, halted, addr_err, fetch_count
  );

  modport slave (
    input  start, stall, pcsrc, branch_target, imem_we, imem_waddr, imem_wdata,
    output pc, npc, instr, valid, halted, addr_err, fetch_count
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, word-addressed instruction ROM with a
// load port, IDLE/RUN/HALT control and a saturating accepted-fetch counter.
module if_fetch_unit #(
  parameter int          MEM_DEPTH = 128,
  parameter int          ADDR_W    = 7,
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input logic         clk,
  input logic         rst,
  if_fetch_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        addr_err_q, addr_err_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [31:0] mem [MEM_DEPTH];

  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_word;
  logic              pc_illegal;
  logic              is_halt_word;
  logic              fetch_valid;

  // Contents survive reset so a loaded program can be re-run.
  always_ff @(posedge clk) begin
    if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
  end

  assign rd_idx       = pc_q[ADDR_W+1:2];
  assign rd_word      = mem[rd_idx];
  assign pc_illegal   = (pc_q[1:0] != 2'b00) || (pc_q[31:ADDR_W+2] != '0);
  assign is_halt_word = (rd_word == HALT_WORD);
  assign fetch_valid  = (state_q == RUN) && !pc_illegal && !is_halt_word;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_err_d    = addr_err_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        // Redirect beats stall, halt word and address error alike.
        if (bus.pcsrc) begin
          pc_d = bus.branch_target;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (pc_illegal) begin
          state_d    = HALT;
          addr_err_d = 1'b1;
        end else if (is_halt_word) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (fetch_valid && !bus.stall && !bus.pcsrc && fetch_count_q != 16'hFFFF)
      fetch_count_d = fetch_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      addr_err_q    <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_err_q    <= addr_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.npc         = pc_q + 32'd4;
  assign bus.instr       = fetch_valid ? rd_word : 32'h00000000;
  assign bus.valid       = fetch_valid;
  assign bus.halted      = (state_q == HALT);
  assign bus.addr_err    = addr_err_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: program run, stall, redirect priority,
// illegal targets, reset mid-run, live memory writes and counter saturation.
module tb_if_fetch_unit;
  localparam logic [31:0] HALTW = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  if_fetch_if #(.ADDR_W(7)) bus ();

  if_fetch_unit #(
    .MEM_DEPTH(128), .ADDR_W(7), .RESET_PC(32'h0), .HALT_WORD(HALTW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_seq(input int n, input logic [31:0] base);
    bus.imem_we = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.imem_waddr = 7'(i);
      bus.imem_wdata = base + 32'(i);
      tick();
    end
    bus.imem_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset_and_program();
    rst = 1'b1;
    tick();
    n_chk++; if (bus.pc !== 32'h0) $display("FAIL rst_pc: got %h exp %h", bus.pc, 32'h0); else n_pass++;
    n_chk++; if (bus.valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus.valid); else n_pass++;
    n_chk++; if (bus.halted !== 1'b0) $display("FAIL rst_halted: got %b exp 0", bus.halted); else n_pass++;
    n_chk++; if (bus.fetch_count !== 16'h0) $display("FAIL rst_count: got %h exp 0", bus.fetch_count); else n_pass++;
    n_chk++; if (bus.addr_err !== 1'b0) $display("FAIL rst_err: got %b exp 0", bus.addr_err); else n_pass++;
    rst = 1'b0;
    bus.imem_we = 1'b1;
    bus.imem_waddr = 7'd0; bus.imem_wdata = 32'h20080005; tick();
    bus.imem_waddr = 7'd1; bus.imem_wdata = 32'h20090003; tick();
    bus.imem_waddr = 7'd2; bus.imem_wdata = HALTW;        tick();
    bus.imem_we = 1'b0;
    n_chk++; if (bus.valid !== 1'b0 || bus.instr !== 32'h0) $display("FAIL idle_out: valid %b instr %h exp 0/0", bus.valid, bus.instr); else n_pass++;
    n_chk++; if (bus.pc !== 32'h0) $display("FAIL idle_pc: got %h exp 0", bus.pc); else n_pass++;
    pulse_start();
    n_chk++; if (bus.valid !== 1'b1 || bus.instr !== 32'h20080005) $display("FAIL p0_fetch: valid %b instr %h exp 1/20080005", bus.valid, bus.instr); else n_pass++;
    n_chk++; if (bus.npc !== 32'h4) $display("FAIL p0_npc: got %h exp 4", bus.npc); else n_pass++;
    tick();
    n_chk++; if (bus.pc !== 32'h4 || bus.instr !== 32'h20090003 || bus.valid !== 1'b1) $display("FAIL p1_fetch: pc %h instr %h valid %b exp 4/20090003/1", bus.pc, bus.instr, bus.valid); else n_pass++;
    n_chk++; if (bus.npc !== 32'h8) $display("FAIL p1_npc: got %h exp 8", bus.npc); else n_pass++;
    tick();
    n_chk++; if (bus.pc !== 32'h8 || bus.valid !== 1'b0 || bus.instr !== 32'h0 || bus.halted !== 1'b0) $display("FAIL p2_haltword: pc %h valid %b instr %h halted %b exp 8/0/0/0", bus.pc, bus.valid, bus.instr, bus.halted); else n_pass++;
    tick();
    n_chk++; if (bus.halted !== 1'b1 || bus.pc !== 32'h8) $display("FAIL p2_halted: halted %b pc %h exp 1/8", bus.halted, bus.pc); else n_pass++;
    n_chk++; if (bus.fetch_count !== 16'd2) $display("FAIL p2_count: got %0d exp 2", bus.fetch_count); else n_pass++;
    n_chk++; if (bus.addr_err !== 1'b0) $display("FAIL p2_err: got %b exp 0", bus.addr_err); else n_pass++;
    pulse_start();
    tick();
    n_chk++; if (bus.halted !== 1'b1 || bus.pc !== 32'h8 || bus.valid !== 1'b0) $display("FAIL halt_sticky: halted %b pc %h valid %b exp 1/8/0", bus.halted, bus.pc, bus.valid); else n_pass++;
  endtask

  task automatic test_stall();
    load_seq(32, 32'h10000000);
    do_reset();
    pulse_start();
    repeat (4) tick();
    n_chk++; if (bus.pc !== 32'h10 || bus.fetch_count !== 16'd4) $display("FAIL stall_pre: pc %h count %0d exp 10/4", bus.pc, bus.fetch_count); else n_pass++;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (bus.pc !== 32'h10 || bus.instr !== 32'h10000004 || bus.fetch_count !== 16'd4) $display("FAIL stall_hold%0d: pc %h instr %h count %0d exp 10/10000004/4", i, bus.pc, bus.instr, bus.fetch_count); else n_pass++;
    end
    bus.stall = 1'b0;
    tick();
    n_chk++; if (bus.pc !== 32'h14 || bus.fetch_count !== 16'd5) $display("FAIL stall_release: pc %h count %0d exp 14/5", bus.pc, bus.fetch_count); else n_pass++;
  endtask

  task automatic test_branch_over_stall();
    do_reset();
    pulse_start();
    repeat (2) tick();
    n_chk++; if (bus.pc !== 32'h8 || bus.fetch_count !== 16'd2) $display("FAIL br_pre: pc %h count %0d exp 8/2", bus.pc, bus.fetch_count); else n_pass++;
    bus.stall = 1'b1; bus.pcsrc = 1'b1; bus.branch_target = 32'h40;
    tick();
    bus.stall = 1'b0; bus.pcsrc = 1'b0;
    n_chk++; if (bus.pc !== 32'h40 || bus.fetch_count !== 16'd2) $display("FAIL br_taken: pc %h count %0d exp 40/2", bus.pc, bus.fetch_count); else n_pass++;
    n_chk++; if (bus.valid !== 1'b1 || bus.instr !== 32'h10000010) $display("FAIL br_fetch: valid %b instr %h exp 1/10000010", bus.valid, bus.instr); else n_pass++;
    tick();
    n_chk++; if (bus.pc !== 32'h44 || bus.fetch_count !== 16'd3) $display("FAIL br_next: pc %h count %0d exp 44/3", bus.pc, bus.fetch_count); else n_pass++;
  endtask

  task automatic test_illegal_target();
    bus.pcsrc = 1'b1; bus.branch_target = 32'h42;
    tick();
    bus.pcsrc = 1'b0;
    n_chk++; if (bus.pc !== 32'h42 || bus.valid !== 1'b0 || bus.instr !== 32'h0 || bus.halted !== 1'b0) $display("FAIL mis_cycle: pc %h valid %b instr %h halted %b exp 42/0/0/0", bus.pc, bus.valid, bus.instr, bus.halted); else n_pass++;
    tick();
    n_chk++; if (bus.halted !== 1'b1 || bus.addr_err !== 1'b1 || bus.pc !== 32'h42) $display("FAIL mis_halt: halted %b err %b pc %h exp 1/1/42", bus.halted, bus.addr_err, bus.pc); else n_pass++;
    do_reset();
    n_chk++; if (bus.addr_err !== 1'b0) $display("FAIL err_clear: got %b exp 0", bus.addr_err); else n_pass++;
    pulse_start();
    bus.pcsrc = 1'b1; bus.branch_target = 32'h200;
    tick();
    bus.pcsrc = 1'b0;
    n_chk++; if (bus.pc !== 32'h200 || bus.valid !== 1'b0 || bus.halted !== 1'b0) $display("FAIL oor_cycle: pc %h valid %b halted %b exp 200/0/0", bus.pc, bus.valid, bus.halted); else n_pass++;
    tick();
    n_chk++; if (bus.halted !== 1'b1 || bus.addr_err !== 1'b1 || bus.pc !== 32'h200) $display("FAIL oor_halt: halted %b err %b pc %h exp 1/1/200", bus.halted, bus.addr_err, bus.pc); else n_pass++;
  endtask

  task automatic test_redirect_on_halt_and_reset();
    bus.imem_we = 1'b1; bus.imem_waddr = 7'd3; bus.imem_wdata = HALTW;
    tick();
    bus.imem_we = 1'b0;
    do_reset();
    pulse_start();
    repeat (3) tick();
    n_chk++; if (bus.pc !== 32'hC || bus.valid !== 1'b0) $display("FAIL hw_at_c: pc %h valid %b exp c/0", bus.pc, bus.valid); else n_pass++;
    bus.pcsrc = 1'b1; bus.branch_target = 32'h0;
    tick();
    bus.pcsrc = 1'b0;
    n_chk++; if (bus.pc !== 32'h0 || bus.halted !== 1'b0 || bus.valid !== 1'b1 || bus.instr !== 32'h10000000) $display("FAIL hw_redirect: pc %h halted %b valid %b instr %h exp 0/0/1/10000000", bus.pc, bus.halted, bus.valid, bus.instr); else n_pass++;
    n_chk++; if (bus.fetch_count !== 16'd3) $display("FAIL hw_count: got %0d exp 3", bus.fetch_count); else n_pass++;
    tick();
    rst = 1'b1; bus.start = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    n_chk++; if (bus.pc !== 32'h0 || bus.valid !== 1'b0 || bus.halted !== 1'b0 || bus.fetch_count !== 16'd0) $display("FAIL midrun_rst: pc %h valid %b halted %b count %0d exp 0/0/0/0", bus.pc, bus.valid, bus.halted, bus.fetch_count); else n_pass++;
    tick();
    n_chk++; if (bus.valid !== 1'b0 || bus.pc !== 32'h0) $display("FAIL rst_idle: valid %b pc %h exp 0/0", bus.valid, bus.pc); else n_pass++;
    pulse_start();
    n_chk++; if (bus.valid !== 1'b1 || bus.instr !== 32'h10000000) $display("FAIL mem_kept: valid %b instr %h exp 1/10000000", bus.valid, bus.instr); else n_pass++;
  endtask

  task automatic test_live_write_and_saturation();
    int cyc;
    bus.stall = 1'b1;
    bus.imem_we = 1'b1; bus.imem_waddr = 7'd0; bus.imem_wdata = 32'hABCD0001;
    tick();
    bus.imem_we = 1'b0; bus.stall = 1'b0;
    n_chk++; if (bus.pc !== 32'h0 || bus.instr !== 32'hABCD0001) $display("FAIL live_write: pc %h instr %h exp 0/abcd0001", bus.pc, bus.instr); else n_pass++;
    bus.imem_we = 1'b1;
    for (int i = 0; i < 128; i++) begin
      bus.imem_waddr = 7'(i);
      bus.imem_wdata = 32'h00000013;
      tick();
    end
    bus.imem_we = 1'b0;
    do_reset();
    pulse_start();
    cyc = 0;
    while (bus.fetch_count !== 16'hFFFF && cyc < 70000) begin
      bus.pcsrc = (bus.pc == 32'h1FC);
      bus.branch_target = 32'h0;
      tick();
      cyc++;
    end
    for (int i = 0; i < 300; i++) begin
      bus.pcsrc = (bus.pc == 32'h1FC);
      tick();
    end
    bus.pcsrc = 1'b0;
    n_chk++; if (bus.fetch_count !== 16'hFFFF) $display("FAIL sat_count: got %h exp ffff after %0d cycles", bus.fetch_count, cyc); else n_pass++;
    n_chk++; if (bus.halted !== 1'b0 || bus.addr_err !== 1'b0) $display("FAIL sat_running: halted %b err %b exp 0/0", bus.halted, bus.addr_err); else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0; bus.stall = 1'b0; bus.pcsrc = 1'b0; bus.branch_target = 32'h0;
    bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = 32'h0;
    test_reset_and_program();
    test_stall();
    test_branch_over_stall();
    test_illegal_target();
    test_redirect_on_halt_and_reset();
    test_live_write_and_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
